video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
- Generates pixel-counter timing for the arcade core: 6 MHz pixel enable, PH/PV counters, blanking and sync.
- Registers the core's 12-bit pixel output into blank-gated RGB, aligned to delayed sync/blank.
- Sits directly upstream (PH/PV) and downstream (POUT) of the game top level; feeds the MiSTer video mixer.

Parameters:
- H_TOTAL, 384, pixels per line (hcnt 0..H_TOTAL-1)
- H_ACTIVE, 256, visible pixels; HBLK when hcnt >= H_ACTIVE
- HS_START, 288, hcnt at which HSYNC begins (before offset)
- HS_WIDTH, 32, HSYNC length in pixels
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines; VBLK when vcnt >= V_ACTIVE
- VS_START, 240, vcnt at which VSYNC begins (before offset)
- VS_WIDTH, 8, VSYNC length in lines
- V_BASE, 16, added to vcnt to form PV
- PIPE_DLY, 2, pixel periods between PH/PV and matching POUT (1..7)

Ports:
- clk48M in 1: system clock
- reset in 1: synchronous, active-high
- HOFFS in 4: signed horizontal sync shift, -8..+7 pixels
- VOFFS in 4: signed vertical sync shift, -8..+7 lines
- POUT in 12: pixel from core, {B[3:0],G[3:0],R[3:0]}
- CE_PIX out 1: pixel enable, one clk48M cycle in 8
- PH out 9: horizontal count to core
- PV out 9: vertical count to core, vcnt+V_BASE mod 512
- HBLK out 1: delayed horizontal blank
- VBLK out 1: delayed vertical blank
- HSYN out 1: delayed HSYNC, active high
- VSYN out 1: delayed VSYNC, active high
- R,G,B out 4 each: registered pixel, zero while blanked

Behaviour:
- Clock and reset: one clock, clk48M; reset is synchronous, active-high.
- Reset values:
  - div=0, hcnt=0, vcnt=0, CE_PIX=0
  - PH=0, PV=V_BASE
  - HBLK=VBLK=1, HSYN=VSYN=0, R=G=B=0
  - delay lines filled with blank=1, sync=0
  - latched offsets=0
- CE_PIX: 3-bit div increments every clk48M. CE_PIX is high the cycle div==7, so the first pulse comes 8 cycles after reset release. No pause input; timing always runs.
- Counters, updated on the CE_PIX cycle only:
  - hcnt wraps H_TOTAL-1 -> 0.
  - On that wrap, vcnt increments, wrapping V_TOTAL-1 -> 0.
  - PH and PV are combinational from hcnt and vcnt.
- Offset latch: HOFFS/VOFFS are sampled into internal regs only when hcnt and vcnt both wrap to 0. Mid-frame changes take effect next frame.
- Raw sync (computed in 10-bit signed, modulo total):
  - hs = hcnt in [HS_START+hoffs, HS_START+hoffs+HS_WIDTH-1]
  - vs = vcnt in [VS_START+voffs, VS_START+voffs+VS_WIDTH-1]
  - Windows crossing the total wrap around to 0.
- Raw blank: hb = hcnt>=H_ACTIVE; vb = vcnt>=V_ACTIVE.
- Delay: {hb,vb,hs,vs} pass through a PIPE_DLY-stage shift register advanced on CE_PIX. Outputs HBLK/VBLK/HSYN/VSYN are the last stage.
- RGB: on CE_PIX, if the delayed hb|vb is set, R=G=B=0; otherwise R=POUT[3:0], G=POUT[7:4], B=POUT[11:8]. RGB is registered in the same stage as the delayed flags, so both change together.
- Outputs change only on CE_PIX cycles, except at reset.
- Reset mid-frame: all state returns to reset values on the next clk48M edge, and timing restarts at line 0, pixel 0.

Decomposition:
- Shared package: timing defaults (H_TOTAL etc.), RGB444 field offsets, and a 4-field sync/blank struct or typedef.
- One natural sub-module: `pix_delay_line`, a parameterised PIPE_DLY x 4-bit shift register with enable and reset fill value.
- Counters and RGB gating stay in the top.

Test Plan:
- Release reset, count clk48M -> first CE_PIX at cycle 8, then every 8 cycles; PH goes 0,1,2...
- Run one line -> PH 383 -> 0 and PV 16 -> 17 on the same CE_PIX; 384*264 CE_PIX per frame; VBLK high for vcnt 224..263.
- HOFFS=0, PIPE_DLY=2 -> HSYN rises exactly 2 CE_PIX after hcnt==288 and lasts 32 CE_PIX. HOFFS=-8 -> rise at hcnt 280 (+2 delay).
- Change VOFFS from 0 to 5 mid-frame (vcnt=100) -> VSYN still at vcnt 240..247 this frame, 245..252 next frame.
- POUT=12'hABC during active area -> B=A, G=B, R=C two CE_PIX later. Same POUT while HBLK -> R=G=B=0.
- Assert reset for 1 cycle at hcnt=200, vcnt=150 -> next cycle PH=0, PV=16, HBLK=VBLK=1, syncs 0, RGB 0.

Source files
------------

// File: rtl/video_timing_gen_pkg.sv
// rtl/video_timing_gen_pkg.sv - shared timing defaults, RGB444 layout and sync/blank helpers
//
// Purpose: default raster geometry for the arcade core, the field layout of the
// 12-bit pixel word, the packed sync/blank bundle carried through the delay line,
// and the modulo sync-window test used for both axes.
package video_timing_gen_pkg;

   localparam int DEF_H_TOTAL  = 384;
   localparam int DEF_H_ACTIVE = 256;
   localparam int DEF_HS_START = 288;
   localparam int DEF_HS_WIDTH = 32;
   localparam int DEF_V_TOTAL  = 264;
   localparam int DEF_V_ACTIVE = 224;
   localparam int DEF_VS_START = 240;
   localparam int DEF_VS_WIDTH = 8;
   localparam int DEF_V_BASE   = 16;
   localparam int DEF_PIPE_DLY = 2;

   // POUT = {B[3:0], G[3:0], R[3:0]}
   localparam int R_LSB = 0;
   localparam int G_LSB = 4;
   localparam int B_LSB = 8;

   typedef struct packed {
      logic hb;
      logic vb;
      logic hs;
      logic vs;
   } sync_blank_t;

   // Idle raster state: blanked, no sync.
   localparam sync_blank_t SB_RESET = '{hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};

   // True when cnt lies in the window [start+offs, start+offs+width-1], taken
   // modulo total so a window that runs past the end of the line/frame wraps to 0.
   function automatic logic in_window(input logic [8:0]        cnt,
                                      input logic signed [3:0] offs,
                                      input logic [9:0]        start,
                                      input logic [9:0]        width,
                                      input logic [9:0]        total);
      logic signed [9:0] s;
      logic signed [9:0] d;
      s = $signed(start) + $signed({{6{offs[3]}}, offs});
      if (s < 10'sd0)
         s = s + $signed(total);
      else if (s >= $signed(total))
         s = s - $signed(total);
      d = $signed({1'b0, cnt}) - s;
      if (d < 10'sd0)
         d = d + $signed(total);
      return (d < $signed(width));
   endfunction

endpackage

// File: rtl/video_timing_gen_delay_line.sv
// rtl/video_timing_gen_delay_line.sv - enabled shift register with reset fill value
//
// Purpose: delays the raw sync/blank bundle by DEPTH pixel periods.
// Ports:
//   clk48M    - system clock
//   reset     - synchronous, active-high; loads every stage with FILL
//   en        - advance the pipe (pixel enable)
//   din       - value entering stage 0
//   dout      - last stage
//   dout_next - value that will enter the last stage on the next enabled edge
module pix_delay_line #(
   parameter int               DEPTH = 2,
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] FILL  = '0
) (
   input  logic             clk48M,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] dout_next
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk48M) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            stage[i] <= FILL;
      end else if (en) begin
         stage[0] <= din;
         for (int i = 1; i < DEPTH; i++)
            stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

   // Lets a downstream register load alongside the last stage.
   generate
      if (DEPTH == 1) begin : g_next_din
         assign dout_next = din;
      end else begin : g_next_stage
         assign dout_next = stage[DEPTH-2];
      end
   endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - pixel timing, sync/blank generation and blank-gated RGB output
//
// Purpose: divides clk48M by 8 into a pixel enable, runs the PH/PV raster
// counters, derives offset-adjustable sync and blanking, delays them to line up
// with the core's pixel output, and registers blank-gated RGB.
// Ports:
//   clk48M       - system clock
//   reset        - synchronous, active-high
//   HOFFS, VOFFS - signed sync shifts, latched at the start of each frame
//   POUT         - pixel from core {B,G,R}
//   CE_PIX       - pixel enable, high one cycle in 8
//   PH, PV       - raster position to the core (PV offset by V_BASE)
//   HBLK, VBLK   - delayed blanking
//   HSYN, VSYN   - delayed sync, active high
//   R, G, B      - registered pixel, zero while blanked
module video_timing_gen
   import video_timing_gen_pkg::*;
#(
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_WIDTH = DEF_HS_WIDTH,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_WIDTH = DEF_VS_WIDTH,
   parameter int V_BASE   = DEF_V_BASE,
   parameter int PIPE_DLY = DEF_PIPE_DLY
) (
   input  logic        clk48M,
   input  logic        reset,
   input  logic [3:0]  HOFFS,
   input  logic [3:0]  VOFFS,
   input  logic [11:0] POUT,
   output logic        CE_PIX,
   output logic [8:0]  PH,
   output logic [8:0]  PV,
   output logic        HBLK,
   output logic        VBLK,
   output logic        HSYN,
   output logic        VSYN,
   output logic [3:0]  R,
   output logic [3:0]  G,
   output logic [3:0]  B
);

   logic [2:0]        div;
   logic [8:0]        hcnt;
   logic [8:0]        vcnt;
   logic signed [3:0] hoffs_q;
   logic signed [3:0] voffs_q;
   logic [3:0]        r_q;
   logic [3:0]        g_q;
   logic [3:0]        b_q;
   logic              h_wrap;
   logic              v_wrap;
   sync_blank_t       raw_sb;
   sync_blank_t       dly_sb;
   sync_blank_t       dly_sb_next;

   assign CE_PIX = (div == 3'd7);
   assign h_wrap = (hcnt == 9'(H_TOTAL - 1));
   assign v_wrap = (vcnt == 9'(V_TOTAL - 1));

   always_ff @(posedge clk48M) begin
      if (reset) begin
         div     <= 3'd0;
         hcnt    <= 9'd0;
         vcnt    <= 9'd0;
         hoffs_q <= 4'sd0;
         voffs_q <= 4'sd0;
         r_q     <= 4'd0;
         g_q     <= 4'd0;
         b_q     <= 4'd0;
      end else begin
         div <= div + 3'd1;
         if (CE_PIX) begin
            if (h_wrap) begin
               hcnt <= 9'd0;
               if (v_wrap) begin
                  vcnt    <= 9'd0;
                  // Offsets only move at frame start so a frame never sees a torn sync.
                  hoffs_q <= $signed(HOFFS);
                  voffs_q <= $signed(VOFFS);
               end else begin
                  vcnt <= vcnt + 9'd1;
               end
            end else begin
               hcnt <= hcnt + 9'd1;
            end

            // Gate with the flags entering the last delay stage, so RGB and
            // HBLK/VBLK switch on the same edge.
            if (dly_sb_next.hb || dly_sb_next.vb) begin
               r_q <= 4'd0;
               g_q <= 4'd0;
               b_q <= 4'd0;
            end else begin
               r_q <= POUT[R_LSB +: 4];
               g_q <= POUT[G_LSB +: 4];
               b_q <= POUT[B_LSB +: 4];
            end
         end
      end
   end

   always_comb begin
      raw_sb    = SB_RESET;
      raw_sb.hb = (hcnt >= 9'(H_ACTIVE));
      raw_sb.vb = (vcnt >= 9'(V_ACTIVE));
      raw_sb.hs = in_window(hcnt, hoffs_q, 10'(HS_START), 10'(HS_WIDTH), 10'(H_TOTAL));
      raw_sb.vs = in_window(vcnt, voffs_q, 10'(VS_START), 10'(VS_WIDTH), 10'(V_TOTAL));
   end

   pix_delay_line #(
      .DEPTH (PIPE_DLY),
      .WIDTH (4),
      .FILL  (SB_RESET)
   ) u_delay (
      .clk48M    (clk48M),
      .reset     (reset),
      .en        (CE_PIX),
      .din       (raw_sb),
      .dout      (dly_sb),
      .dout_next (dly_sb_next)
   );

   assign PH   = hcnt;
   assign PV   = vcnt + 9'(V_BASE);
   assign HBLK = dly_sb.hb;
   assign VBLK = dly_sb.vb;
   assign HSYN = dly_sb.hs;
   assign VSYN = dly_sb.vs;
   assign R    = r_q;
   assign G    = g_q;
   assign B    = b_q;

endmodule
